alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Initiator side of the alu_8 interface. Accepts one ALU instruction at a time over a valid/ready
//  request port, reads operands from an internal 8x8 register file (or an immediate), drives
//  a/b/opcode into an external alu_8 and captures its combinational result. It then returns
//  result+flags over a valid/ready response port and writes the result back to the register file.
//  Sits between the Z80 decode stage and the alu_8 datapath.
// PARAMETERS
//  NREGS      8   register file depth (index width = $clog2(NREGS), fixed 3 here)
//  ALU_SETTLE 1   cycles alu_a/alu_b/alu_opcode are held before alu_result is sampled (>=1)
// PORTS
//  clk          in   1  single clock, rising edge
//  rst          in   1  asynchronous, active-high reset
//  req_valid    in   1  request present
//  req_ready    out  1  sequencer can accept request
//  req_opcode   in   4  alu_8 opcode (0 add,1 sub,2 and,3 or,4 xor,6 sll,7 srl,8 sla,9 sra,10 rot,13 set,14 res,15 test)
//  req_src_a    in   3  register index for operand a
//  req_src_b    in   3  register index for operand b (ignored when req_use_imm=1)
//  req_use_imm  in   1  1: operand b = req_imm
//  req_imm      in   8  immediate operand b
//  req_dst      in   3  destination register index
//  rsp_valid    out  1  response present
//  rsp_ready    in   1  consumer accepts response
//  rsp_data     out  8  captured ALU result
//  rsp_flags    out  3  {E,S,Z}: E illegal opcode, S=rsp_data[7], Z=(rsp_data==0)
//  alu_a        out  8  to alu_8.a (registered)
//  alu_b        out  8  to alu_8.b (registered)
//  alu_opcode   out  4  to alu_8.opcode (registered)
//  alu_result   in   8  from alu_8.out (combinational)
//  dbg_addr     in   3  debug register read index
//  dbg_data     out  8  regfile[dbg_addr], combinational
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, all regfile entries 0, req_ready=1, rsp_valid=0,
//    rsp_data=0, rsp_flags=0, alu_a/alu_b/alu_opcode=0.
//  - Single outstanding op; no hazards possible. FSM: IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE.
//  - IDLE: req_ready=1. On req_valid&req_ready: alu_a<=reg[src_a], alu_b<=use_imm?imm:reg[src_b],
//    alu_opcode<=req_opcode, latch dst and illegal bit (opcodes 5,11,12) -> ISSUE.
//  - ISSUE: req_ready=0; holds ALU inputs for ALU_SETTLE cycles (counter) -> CAPTURE.
//  - CAPTURE: rsp_data<=alu_result, rsp_flags<={illegal, alu_result[7], alu_result==0} -> RESP.
//    Illegal opcode: rsp_data<=0, flags={1,0,0}.
//  - RESP: rsp_valid=1; rsp_data/rsp_flags stable until accept. On rsp_valid&rsp_ready:
//    reg[dst]<=rsp_data unless opcode==15 (test) or illegal -> IDLE. Writeback occurs on the
//    accept edge only; back-pressure delays it indefinitely.
//  - Latency (ALU_SETTLE=1): request accept edge -> rsp_valid high 3 cycles later; earliest next
//    accept is the cycle after response accept (1 op per 4 cycles).
//  - alu_a/alu_b/alu_opcode hold their last values after the op (not cleared).
//  - src==dst allowed; operands are read at accept, so the writeback never affects the current op.
//  - Reset mid-operation: op abandoned, no writeback, every output returns to its reset value.
//  - req_* ignored when req_ready=0; rsp_ready ignored when rsp_valid=0.
// TESTING
//  1 Assert rst for 2 cycles mid-idle -> req_ready=1, rsp_valid=0, alu_opcode=0, dbg_data=0 for all 8 idx.
//  2 ADD r0+imm 7 ->r1, then ADD r1+r1 ->r2 -> rsp_data 0x07 then 0x0E, flags 000; dbg r2=0x0E;
//    rsp_valid exactly 3 cycles after each accept.
//  3 ADD r0+imm 0xCA ->r3, SRA r3 by imm 3 ->r4 -> rsp_data 0xF9, flags S=1; alu_a=0xCA, alu_b=3, alu_opcode=9.
//  4 rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_data stable, req_ready=0, dbg[dst] unchanged
//    until the accept edge.
//  5 Opcode 5 -> flags 100, rsp_data 0, dst unchanged; opcode 15 on r1 -> flags produced, r1 unchanged.
//  6 Assert rst while in CAPTURE of ADD ->r5 -> r5 stays 0, FSM IDLE, rsp_valid never asserted.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Initiator for an external alu_8: takes one instruction over a valid/ready request port,
// sequences operands from an 8x8 register file, returns result+flags and writes the result back.
module alu_op_sequencer #(
  parameter int NREGS      = 8,
  parameter int ALU_SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_opcode,
  input  logic [2:0] req_src_a,
  input  logic [2:0] req_src_b,
  input  logic       req_use_imm,
  input  logic [7:0] req_imm,
  input  logic [2:0] req_dst,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [2:0] rsp_flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic [2:0] dbg_addr,
  output logic [7:0] dbg_data
);

  localparam int CW = (ALU_SETTLE > 1) ? $clog2(ALU_SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'd5) || (op == 4'd11) || (op == 4'd12);
  endfunction

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    alu_a_q, alu_a_d;
  logic [7:0]    alu_b_q, alu_b_d;
  logic [3:0]    alu_op_q, alu_op_d;
  logic [2:0]    dst_q, dst_d;
  logic          ill_q, ill_d;
  logic [7:0]    rsp_data_q, rsp_data_d;
  logic [2:0]    rsp_flags_q, rsp_flags_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          req_ready_q, req_ready_d;
  logic [7:0]    regs_q [NREGS];
  logic [7:0]    regs_d [NREGS];

  // Next-state, datapath capture and register-file writeback
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    dst_d       = dst_q;
    ill_d       = ill_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    regs_d      = regs_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          alu_a_d  = regs_q[req_src_a];
          alu_b_d  = req_use_imm ? req_imm : regs_q[req_src_b];
          alu_op_d = req_opcode;
          dst_d    = req_dst;
          ill_d    = is_illegal(req_opcode);
          cnt_d    = CW'(ALU_SETTLE - 1);
          state_d  = S_ISSUE;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          state_d = S_CAPTURE;
        end else begin
          cnt_d   = cnt_q - CW'(1);
        end
      end
      S_CAPTURE: begin
        // Illegal opcodes never expose whatever the ALU drove for them
        if (ill_q) begin
          rsp_data_d  = 8'h00;
          rsp_flags_d = 3'b100;
        end else begin
          rsp_data_d  = alu_result;
          rsp_flags_d = {1'b0, alu_result[7], (alu_result == 8'h00)};
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          if (!ill_q && (alu_op_q != 4'd15)) begin
            regs_d[dst_q] = rsp_data_q;
          end else begin
            regs_d = regs_q;
          end
          state_d = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
  end

  // State, datapath and handshake registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= 8'h00;
      alu_b_q     <= 8'h00;
      alu_op_q    <= 4'h0;
      dst_q       <= 3'd0;
      ill_q       <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_flags_q <= 3'b000;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      dst_q       <= dst_d;
      ill_q       <= ill_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
    end
  end

  // Register file storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign dbg_data   = regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: a behavioural alu_8 drives alu_result, a reference
// register-file model predicts every response, and a monitor checks responses as they are accepted.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_use_imm;
  logic [3:0] req_opcode;
  logic [2:0] req_src_a, req_src_b, req_dst;
  logic [7:0] req_imm;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic [2:0] rsp_flags;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_opcode;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0]  mreg [8];
  logic [10:0] exp_q [$];

  alu_op_sequencer #(.NREGS(8), .ALU_SETTLE(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_use_imm(req_use_imm),
    .req_imm(req_imm), .req_dst(req_dst),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_result(alu_result),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Behavioural alu_8; undefined opcodes return junk so the sequencer must mask them
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic signed [7:0] sa;
    logic [15:0] rr;
    sa = a;
    rr = {a, a} << b[2:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd6:  return a << b[2:0];
      4'd7:  return a >> b[2:0];
      4'd8:  return a << b[2:0];
      4'd9:  return sa >>> b[2:0];
      4'd10: return rr[15:8];
      4'd13: return a | (8'd1 << b[2:0]);
      4'd14: return a & ~(8'd1 << b[2:0]);
      4'd15: return a & (8'd1 << b[2:0]);
      default: return 8'hA5;
    endcase
  endfunction

  assign alu_result = alu_f(alu_a, alu_b, alu_opcode);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the response about to be accepted must match the oldest prediction
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("rsp_data", {24'd0, rsp_data}, {24'd0, e[7:0]});
        check("rsp_flags", {29'd0, rsp_flags}, {29'd0, e[10:8]});
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] sa, input logic [2:0] sb,
                       input logic ui, input logic [7:0] imm, input logic [2:0] dst,
                       input int stall, input bit chk_stall);
    logic [7:0] a, b, res, old;
    logic ill;
    bit ok;
    int cnt;
    a   = mreg[sa];
    b   = ui ? imm : mreg[sb];
    ill = (op == 4'd5) || (op == 4'd11) || (op == 4'd12);
    res = ill ? 8'h00 : alu_f(a, b, op);
    old = mreg[dst];
    req_opcode = op; req_src_a = sa; req_src_b = sb; req_use_imm = ui; req_imm = imm; req_dst = dst;
    req_valid = 1'b1;
    rsp_ready = (stall == 0);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = req_ready;
      @(posedge clk);
    end
    #1;
    req_valid = 1'b0;
    if (!ok) check("req_accept_timeout", 32'd1, 32'd0);
    exp_q.push_back({ill, res[7], (res == 8'h00) && !ill, res});
    if (!ill && op != 4'd15) mreg[dst] = res;
    dbg_addr = dst;
    cnt = 0;
    while (!rsp_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    // rsp_valid rises on the second edge after the accept edge (accept edge = cycle 1)
    check("rsp_latency", cnt, 32'd2);
    for (int i = 0; i < stall; i++) begin
      if (chk_stall) begin
        check("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_rsp_data", {24'd0, rsp_data}, {24'd0, res});
        check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        check("stall_dbg_dst", {24'd0, dbg_data}, {24'd0, old});
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_req_ready", {31'd0, req_ready}, 32'd1);
    check("writeback_dbg", {24'd0, dbg_data}, {24'd0, mreg[dst]});
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = 4'd0; req_src_a = 3'd0; req_src_b = 3'd0;
    req_use_imm = 1'b0; req_imm = 8'h00; req_dst = 3'd0; rsp_ready = 1'b1; dbg_addr = 3'd0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_rsp_flags", {29'd0, rsp_flags}, 32'd0);
    check("rst_alu_ab", {16'd0, alu_a, alu_b}, 32'd0);
    rst = 1'b0;

    // Dirty the state, then reset while idle
    issue(4'd0, 3'd0, 3'd0, 1'b1, 8'h55, 3'd7, 0, 1'b0);
    issue(4'd4, 3'd7, 3'd0, 1'b1, 8'h0F, 3'd6, 0, 1'b0);
    do_reset();
    check("idle_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("idle_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("idle_rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      check("idle_rst_dbg", {24'd0, dbg_data}, 32'd0);
    end

    issue(4'd0, 3'd0, 3'd0, 1'b1, 8'h07, 3'd1, 0, 1'b0);
    issue(4'd0, 3'd1, 3'd1, 1'b0, 8'h00, 3'd2, 0, 1'b0);
    dbg_addr = 3'd2; #1;
    check("add_r2", {24'd0, dbg_data}, 32'h0E);

    issue(4'd0, 3'd0, 3'd0, 1'b1, 8'hCA, 3'd3, 0, 1'b0);
    issue(4'd9, 3'd3, 3'd0, 1'b1, 8'h03, 3'd4, 0, 1'b0);
    check("sra_alu_a", {24'd0, alu_a}, 32'hCA);
    check("sra_alu_b", {24'd0, alu_b}, 32'h03);
    check("sra_alu_opcode", {28'd0, alu_opcode}, 32'd9);
    dbg_addr = 3'd4; #1;
    check("sra_r4", {24'd0, dbg_data}, 32'hF9);

    issue(4'd0, 3'd2, 3'd0, 1'b1, 8'h01, 3'd6, 5, 1'b1);
    dbg_addr = 3'd6; #1;
    check("stall_r6", {24'd0, dbg_data}, 32'h0F);

    issue(4'd5, 3'd1, 3'd2, 1'b0, 8'h00, 3'd3, 0, 1'b0);
    dbg_addr = 3'd3; #1;
    check("illegal_r3_kept", {24'd0, dbg_data}, 32'hCA);
    issue(4'd15, 3'd1, 3'd0, 1'b1, 8'h00, 3'd1, 1, 1'b0);
    dbg_addr = 3'd1; #1;
    check("test_r1_kept", {24'd0, dbg_data}, 32'h07);

    // Reset while the ADD -> r5 is in CAPTURE
    req_opcode = 4'd0; req_src_a = 3'd2; req_use_imm = 1'b1; req_imm = 8'h05; req_dst = 3'd5;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("rst_capture_no_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 8'h00;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      check("after_rst_no_valid", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk); #1;
    end
    dbg_addr = 3'd5; #1;
    check("rst_capture_r5", {24'd0, dbg_data}, 32'd0);
    check("rst_capture_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_capture_alu_opcode", {28'd0, alu_opcode}, 32'd0);

    // Seed a few registers then run random traffic with random back-pressure
    for (int i = 0; i < 8; i++) issue(4'd0, 3'd0, 3'd0, 1'b1, 8'($urandom), 3'(i), 0, 1'b0);
    for (int n = 0; n < 40; n++) begin
      issue(4'($urandom_range(0, 15)), 3'($urandom), 3'($urandom), 1'($urandom),
            8'($urandom), 3'($urandom), $urandom_range(0, 3), 1'b1);
    end
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i); #1;
      check("final_regfile", {24'd0, dbg_data}, {24'd0, mreg[i]});
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
